ttl_mod_counter_chain: RTL and testbench

//  Parametrised, cascadable modulo-N counter: DIGITS cascaded digits, each counting 0..MODULUS-1.

---
 rtl/ttl_cnt_pkg.sv | 37 +++
 rtl/ttl_mod_counter_digit.sv | 42 ++++
 rtl/ttl_mod_counter_chain.sv | 95 +++++++++
 tb/tb_ttl_mod_counter_chain.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ttl_cnt_pkg.sv
// Shared helpers for the TTL-style cascadable modulo counter: width math,
// terminal values and the per-digit step rule.
`timescale 1ns/1ps
package ttl_cnt_pkg;

  localparam int TERM_DN = 0;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int term_up(input int modulus);
    return modulus - 1;
  endfunction

  // Out-of-range values re-enter the legal range at the wrap point of the direction.
  function automatic int next_digit(input int val, input int modulus, input bit down);
    int r;
    if (down) begin
      if (val == 0 || val >= modulus) r = modulus - 1;
      else r = val - 1;
    end else begin
      if (val >= modulus - 1) r = 0;
      else r = val + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ttl_mod_counter_digit.sv
// One modulo-MODULUS digit of the counter chain, clocked on the falling edge
// with asynchronous clear and ps > ld > step priority.
`timescale 1ns/1ps
module ttl_mod_counter_digit
  import ttl_cnt_pkg::*;
#(
  parameter int W       = 4,
  parameter int MODULUS = 10
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         step,
  input  logic         ps,
  input  logic         ld,
  input  logic         dn,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_i,
  output logic         at_term
);

  localparam logic [W-1:0] TERM_UP_V = W'(term_up(MODULUS));
  localparam logic [W-1:0] TERM_DN_V = W'(TERM_DN);

  logic [W-1:0] next_val;

  assign next_val = W'(next_digit(int'(q_i), MODULUS, dn));

  // Counting up, an out-of-range digit wraps to 0 on its next step, so it carries like the terminal value.
  always_comb begin
    at_term = 1'b0;
    if (dn) at_term = (q_i == TERM_DN_V);
    else    at_term = (q_i >= TERM_UP_V);
  end

  always_ff @(negedge clk or posedge clr) begin
    if (clr)       q_i <= '0;
    else if (ps)   q_i <= TERM_UP_V;
    else if (ld)   q_i <= d_i;
    else if (step) q_i <= next_val;
  end

endmodule

// File: rtl/ttl_mod_counter_chain.sv
// Cascadable modulo-N counter with synchronous lookahead carry, tc and rco.
// Define CNT_UPDOWN_EN to let dn select down counting; otherwise dn is ignored.
`timescale 1ns/1ps
module ttl_mod_counter_chain
  import ttl_cnt_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  parameter int W       = 4,
  parameter int TPLH    = 12,
  parameter int TPHL    = 13
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                ld,
  input  logic                ps,
  input  logic                dn,
  input  logic [DIGITS*W-1:0] d,
  output logic [DIGITS*W-1:0] q,
  output logic                tc,
  output logic                rco
);

  localparam int OW = DIGITS * W + 2;

  if (W < clog2(MODULUS)) begin : g_width_check
    $error("ttl_mod_counter_chain: W=%0d too narrow for MODULUS=%0d", W, MODULUS);
  end

  logic                dn_eff;
  logic [DIGITS-1:0]   at_term;
  logic [DIGITS-1:0]   step;
  logic [DIGITS*W-1:0] q_int;
  logic                tc_int;
  logic                rco_int;
  logic                low_all;

`ifdef CNT_UPDOWN_EN
  assign dn_eff = dn;
`else
  logic unused_dn;
  assign unused_dn = dn;
  assign dn_eff    = 1'b0;
`endif

  // Lookahead: each digit sees the AND of all lower terminal flags, so the whole chain updates on one edge.
  always_comb begin
    step    = '0;
    low_all = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      step[i] = en & low_all;
      low_all = low_all & at_term[i];
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    ttl_mod_counter_digit #(
      .W       (W),
      .MODULUS (MODULUS)
    ) u_digit (
      .clk     (clk),
      .clr     (clr),
      .step    (step[i]),
      .ps      (ps),
      .ld      (ld),
      .dn      (dn_eff),
      .d_i     (d[i*W +: W]),
      .q_i     (q_int[i*W +: W]),
      .at_term (at_term[i])
    );
  end

  assign tc_int  = &at_term;
  assign rco_int = tc_int & en & ~clr;

  logic [OW-1:0] raw;
  logic [OW-1:0] dly_r;
  logic [OW-1:0] dly_f;
  logic [OW-1:0] dly;

  assign raw = {rco_int, tc_int, q_int};
  assign #(TPLH) dly_r = raw;
  assign #(TPHL) dly_f = raw;

  // Combining a TPLH copy and a TPHL copy bitwise gives each bit its own rise and fall delay.
  if (TPLH >= TPHL) begin : g_rise_slow
    assign dly = dly_r & dly_f;
  end else begin : g_fall_slow
    assign dly = dly_r | dly_f;
  end

  assign {rco, tc, q} = dly;

endmodule

// File: tb/tb_ttl_mod_counter_chain.sv
// Directed bench for ttl_mod_counter_chain: zero-delay 2-digit BCD instance for
// cycle behaviour and a 3-digit modulo-6 instance with default output delays.
`timescale 1ns/1ps
module tb_ttl_mod_counter_chain;

  typedef struct {
    logic       clr;
    logic       en;
    logic       ld;
    logic       ps;
    logic       dn;
    logic [7:0] d;
    logic [7:0] q;
    logic       tc;
    logic       rco;
  } vec_t;

  localparam int NVEC = 16;

`ifdef CNT_UPDOWN_EN
  localparam logic       DN_TC0 = 1'b1;
  localparam logic [7:0] DN_Q   = 8'h99;
`else
  localparam logic       DN_TC0 = 1'b0;
  localparam logic [7:0] DN_Q   = 8'h01;
`endif

  logic       clk;
  logic       clr0, en0, ld0, ps0, dn0;
  logic [7:0] d0;
  logic [7:0] q0;
  logic       tc0, rco0;
  logic       clr1, en1, ld1, ps1, dn1;
  logic [8:0] d1;
  logic [8:0] q1;
  logic       tc1, rco1;

  int   vectors;
  int   miscompares;
  vec_t vecs [NVEC];

  ttl_mod_counter_chain #(
    .DIGITS (2), .MODULUS (10), .W (4), .TPLH (0), .TPHL (0)
  ) dut0 (
    .clk (clk), .clr (clr0), .en (en0), .ld (ld0), .ps (ps0), .dn (dn0),
    .d (d0), .q (q0), .tc (tc0), .rco (rco0)
  );

  ttl_mod_counter_chain #(
    .DIGITS (3), .MODULUS (6), .W (3)
  ) dut1 (
    .clk (clk), .clr (clr1), .en (en1), .ld (ld1), .ps (ps1), .dn (dn1),
    .d (d1), .q (q1), .tc (tc1), .rco (rco1)
  );

  initial clk = 1'b1;
  always #20 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx);
    @(posedge clk);
    #5;
    clr0 = vecs[idx].clr;
    en0  = vecs[idx].en;
    ld0  = vecs[idx].ld;
    ps0  = vecs[idx].ps;
    dn0  = vecs[idx].dn;
    d0   = vecs[idx].d;
    @(negedge clk);
    #1;
    checkOutput($sformatf("vec%0d q/tc/rco", idx), {6'b0, q0, tc0, rco0},
                {6'b0, vecs[idx].q, vecs[idx].tc, vecs[idx].rco});
  endtask

  task automatic drive0(input logic c, input logic e, input logic l, input logic p,
                        input logic n, input logic [7:0] dv);
    clr0 = c; en0 = e; ld0 = l; ps0 = p; dn0 = n; d0 = dv;
  endtask

  initial begin
    int cnt;
    logic [7:0] expq;
    vectors     = 0;
    miscompares = 0;
    drive0(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    clr1 = 1'b1; en1 = 1'b0; ld1 = 1'b0; ps1 = 1'b0; dn1 = 1'b0; d1 = '0;

    //          clr   en    ld    ps    dn    d      q      tc    rco
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h39, 8'h39, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h40, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h0C, 8'h0C, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h12, 8'h99, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h95, 8'h95, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h96, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h97, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1};

    for (int i = 0; i < NVEC; i++) applyStimulus(i);

    // Down-count wrap and immediate tc response to dn.
    @(posedge clk); #5;
    drive0(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk); #1;
    checkOutput("dn preload q", {8'b0, q0}, 16'h0000);
    @(posedge clk); #5;
    drive0(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
    #1;
    checkOutput("dn tc/rco at 00", {14'b0, tc0, rco0}, {14'b0, DN_TC0, DN_TC0});
    @(negedge clk); #1;
    checkOutput("dn step from 00", {6'b0, q0, tc0, rco0}, {6'b0, DN_Q, 1'b0, 1'b0});

    // Asynchronous clear between edges, then clr held across a negedge.
    @(posedge clk); #5;
    drive0(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h57);
    @(negedge clk); #1;
    checkOutput("clr preload q", {8'b0, q0}, 16'h0057);
    @(posedge clk); #5;
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("clr async q/tc/rco", {6'b0, q0, tc0, rco0}, 16'h0000);
    @(negedge clk); #1;
    checkOutput("clr held over edge", {6'b0, q0, tc0, rco0}, 16'h0000);
    @(posedge clk); #5;
    clr0 = 1'b0;
    @(negedge clk); #1;
    checkOutput("count after clr release", {8'b0, q0}, 16'h0001);

    // Full 00..99 sweep against a decimal model.
    @(posedge clk); #5;
    clr0 = 1'b1;
    #2;
    clr0 = 1'b0;
    #1;
    checkOutput("sweep start q", {8'b0, q0}, 16'h0000);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); #1;
      cnt  = (cnt + 1) % 100;
      expq = {4'(cnt / 10), 4'(cnt % 10)};
      checkOutput($sformatf("sweep step %0d", k), {6'b0, q0, tc0, rco0},
                  {6'b0, expq, cnt == 99, cnt == 99});
    end
    en0 = 1'b0;

    // Output delays on the modulo-6 instance: rise 12 ns, fall 13 ns.
    @(posedge clk); #5;
    clr1 = 1'b0; en1 = 1'b1; ld1 = 1'b1; d1 = 9'o555;
    @(negedge clk);
    #11;
    checkOutput("delay q/rco before 12ns", {5'b0, q1, tc1, rco1}, 16'h0000);
    #2;
    checkOutput("delay q/tc/rco after 12ns", {5'b0, q1, tc1, rco1}, {5'b0, 9'o555, 1'b1, 1'b1});
    #2;
    en1 = 1'b0; ld1 = 1'b0;
    #11;
    checkOutput("rco before 13ns fall", {15'b0, rco1}, 16'h0001);
    #4;
    checkOutput("rco low with en=0", {14'b0, tc1, rco1}, 16'h0002);
    @(posedge clk); #5;
    en1 = 1'b1;
    @(negedge clk);
    #14;
    checkOutput("mod6 chain wrap", {5'b0, q1, tc1, rco1}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
